// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory behind a req/ready handshake.
// Each accepted request waits LATENCY cycles and then responds with a
// one-cycle ready pulse. Requests that arrive while busy are dropped.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject accesses whose
// byte address is not word aligned. A rejected access raises err together
// with ready, does not store, and leaves readdata unchanged.

module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] readdata,
    output logic        err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0] LAT_M1   = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic [3:0]      cnt;

    // Request fields captured on acceptance
    logic            cap_we;
    logic [AW-1:0]   cap_idx;
    logic [31:0]     cap_wdata;
    logic            cap_mis;

    // Access that takes effect on the edge entering RESP
    logic            acc_we;
    logic [AW-1:0]   acc_idx;
    logic [31:0]     acc_wdata;
    logic            acc_mis;
    logic            do_access;

    logic            in_mis;
    logic            unused_adr;

    logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_ALIGN_CHECK_EN
    assign in_mis = |dataadr[1:0];
`else
    assign in_mis = 1'b0;
`endif

    // Upper address bits wrap away; low bits matter only with the align check
    assign unused_adr = ^{dataadr[31:AW+2], dataadr[1:0]};

    // With zero latency the access happens on the accepting edge, so it must
    // use the live inputs; otherwise it uses the fields captured earlier.
    always_comb begin
        acc_we    = cap_we;
        acc_idx   = cap_idx;
        acc_wdata = cap_wdata;
        acc_mis   = cap_mis;
        if (state == IDLE) begin
            acc_we    = memwrite;
            acc_idx   = dataadr[AW+1:2];
            acc_wdata = writedata;
            acc_mis   = in_mis;
        end
    end

    assign do_access = !reset &&
                       ((state == IDLE && req && ZERO_LAT) ||
                        (state == WAIT && cnt == 4'd0));

    // Latch the request fields whenever a request is accepted
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            cap_we    <= memwrite;
            cap_idx   <= dataadr[AW+1:2];
            cap_wdata <= writedata;
            cap_mis   <= in_mis;
        end
    end

    // Storage array: written only by an accepted, aligned store on response
    always_ff @(posedge clk) begin
        if (do_access && acc_we && !acc_mis) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Handshake FSM with registered busy/ready/err/readdata
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            busy     <= 1'b0;
            ready    <= 1'b0;
            err      <= 1'b0;
            readdata <= 32'd0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if (ZERO_LAT) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (do_access) begin
                ready <= 1'b1;
                err   <= acc_mis;
                if (!acc_we && !acc_mis) begin
                    readdata <= mem[acc_idx];
                end
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MIPS datapath's load/store port, with a request/ready handshake and a configurable wait-state count.
- Services word stores and loads issued by the processor side, which presents `req` plus `memwrite`/`dataadr`/`writedata`.
- Returns `readdata` with a one-cycle `ready` pulse.
- Lets the team run the processor against a memory with latency, so stall logic can be exercised. The existing zero-wait memory cannot do this.

Parameters:
- `DEPTH_WORDS`, 64, number of 32-bit words stored. Must be a power of 2, at least 4.
- `LATENCY`, 2, wait cycles between acceptance and response. Range 0..15.

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `req`  input  1  request valid from processor side
- `memwrite`  input  1  1 = store, 0 = load; sampled with `req`
- `dataadr`  input  32  byte address; sampled with `req`
- `writedata`  input  32  store data; sampled with `req`
- `busy`  output  1  1 = a request is in flight and new `req` is ignored
- `ready`  output  1  one-cycle response strobe
- `readdata`  output  32  load data; valid only while `ready` = 1
- `err`  output  1  valid with `ready`; 1 = request rejected

Behaviour:
- Reset values: `busy` = 0, `ready` = 0, `readdata` = 0, `err` = 0, state = IDLE, wait counter = 0. Memory array contents are not reset.
- Reset is sampled on the rising edge and overrides everything else on that edge.
- Reset mid-operation aborts the request in flight. No write is performed and no `ready` is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - `req` = 1 on an edge captures `memwrite`, `dataadr`, `writedata`.
  - If `LATENCY` = 0, go to RESP; otherwise go to WAIT with counter = `LATENCY` - 1.
  - `busy` = 0 in IDLE.
- WAIT:
  - Counter decrements each cycle.
  - At counter = 0, go to RESP on the next edge.
  - `busy` = 1.
- RESP:
  - On the edge entering RESP, the access is performed.
  - Store: word index = `dataadr[log2(DEPTH_WORDS)+1:2]`; `mem[index]` <= `writedata`.
  - Load: `readdata` <= `mem[index]`.
  - `ready` = 1 for exactly the RESP cycle, and `busy` = 1.
  - Next edge returns to IDLE.
- Handshake latency from `req` edge to `ready` high is `LATENCY` + 1 cycles.
- Minimum request spacing is `LATENCY` + 2 cycles. A `req` seen in the same cycle as `ready` is ignored; it is accepted one cycle later in IDLE.
- `req` while `busy` = 1 is ignored; no queueing.
- `readdata` holds its last load value between responses. A store response does not change `readdata`.
- Addresses beyond the array wrap modulo `DEPTH_WORDS` words; upper address bits are ignored.
- Load from a never-written word returns X in simulation. The bench must preload or write first.

Optional Feature:
- Macro: `DMEM_ALIGN_CHECK_EN`.
- Defined:
  - A request with `dataadr[1:0]` != 0 completes normally through WAIT/RESP timing.
  - In RESP it drives `err` = 1 and `ready` = 1, suppresses the store, and leaves `readdata` unchanged.
  - Aligned requests drive `err` = 0.
- Undefined:
  - `dataadr[1:0]` is ignored (truncated) and `err` is tied to 0.
  - All requests behave as aligned.

Test Plan:
- Reset for 2 cycles, then idle -> `busy` = 0, `ready` = 0, `err` = 0, `readdata` = 0.
- `LATENCY` = 2; store 7 to `dataadr` 84 at cycle t -> `busy` = 1 at t+1..t+3, `ready` = 1 only at t+3. Then a load of 84 -> `readdata` = 32'h00000007 with `ready` 3 cycles after its `req`.
- Hold `req` high continuously with alternating stores to 80/84 -> exactly one `ready` per 4 cycles; requests arriving during `busy` are dropped. Final loads return the last accepted data.
- Store 32'hDEADBEEF to 4 with `DEPTH_WORDS` = 64, then load 260 -> wraps to word 1 and returns 32'hDEADBEEF.
- Assert `reset` during WAIT of a store of 32'h12345678 to 8 (address 8 previously holding 32'h1) -> no `ready`; a load of 8 afterwards returns 32'h00000001.
- With `DMEM_ALIGN_CHECK_EN`, store to 86 (prior contents of 84 = 7) -> `ready` = 1 and `err` = 1; a load of 84 returns 7. Without the macro, the same store writes word 84 and `err` stays 0.
